// File: rtl/digit_scan_controller.sv
// ---------------------------------------------------------------------------
// digit_scan_controller
//   Time-multiplexed digit scanner for N-digit 7-segment displays. It steps
//   through the enabled digits in ascending order. Each enabled digit is
//   driven for PRESCALE cycles. An all-off gap of BLANK_CYCLES cycles
//   separates consecutive digits to prevent ghosting.
//
// Ports
//   clk          in   1           system clock, rising edge
//   rst_n        in   1           asynchronous active-low reset
//   enable       in   1           1 = scan, 0 = display dark
//   digit_mask   in   NUM_DIGITS  bit i = 1 -> digit i participates in scan
//   dig_sel      out  SEL_W       index of the digit currently selected
//   digit        out  NUM_DIGITS  digit enable lines (polarity per ACTIVE_LOW)
//   slot_start   out  1           pulse on the first DRIVE cycle of a slot
//   frame_done   out  1           pulse on the last DRIVE cycle of the frame
// ---------------------------------------------------------------------------
module digit_scan_controller #(
    parameter int NUM_DIGITS   = 8,
    parameter int SEL_W        = 3,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 4,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [SEL_W-1:0]      dig_sel,
    output logic [NUM_DIGITS-1:0] digit,
    output logic                  slot_start,
    output logic                  frame_done
);

    localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DRV_LOAD = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLK_LOAD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [NUM_DIGITS-1:0] OFF = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                              : {NUM_DIGITS{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_DRIVE
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [SEL_W-1:0]      r_sel;
    logic [SEL_W-1:0]      r_next;      // digit for the following slot
    logic                  r_next_vld;  // mask was non-zero when r_next was chosen
    logic [NUM_DIGITS-1:0] r_digit;
    logic                  r_slot_start;
    logic                  r_frame_done;

    logic                  w_mask_any;
    logic [SEL_W-1:0]      w_low;
    logic [SEL_W-1:0]      w_la_base;
    logic [SEL_W:0]        w_above;
    logic [SEL_W-1:0]      w_la_next;
    logic                  w_la_wrap;

    // Lowest set bit of the mask. Returns 0 when the mask is empty.
    function automatic logic [SEL_W-1:0] f_lowest(input logic [NUM_DIGITS-1:0] m);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--)
            if (m[i]) r = SEL_W'(i);
        return r;
    endfunction

    // {found, index} of the lowest set bit strictly above b. Only indices
    // 0..NUM_DIGITS-1 are ever returned.
    function automatic logic [SEL_W:0] f_above(input logic [NUM_DIGITS-1:0] m,
                                               input logic [SEL_W-1:0]      b);
        logic [SEL_W:0] r;
        r = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--)
            if (m[i] && (i > int'(b))) r = {1'b1, SEL_W'(i)};
        return r;
    endfunction

    // Digit-line pattern that drives exactly digit s.
    function automatic logic [NUM_DIGITS-1:0] f_drive(input logic [SEL_W-1:0] s);
        logic [NUM_DIGITS-1:0] oh;
        oh    = '0;
        oh[s] = 1'b1;
        return (ACTIVE_LOW != 0) ? ~oh : oh;
    endfunction

    // Look ahead to choose the next slot. frame_done is a registered output
    // that must appear on the last DRIVE cycle, so the next digit is decided
    // on the edge that enters that cycle. The mask sampled on that edge is
    // the slot-end sample. The base is the digit whose last cycle comes next:
    //   IDLE            -> first digit of a fresh scan (PRESCALE = 1 only)
    //   BLANK           -> r_sel (PRESCALE = 1 only)
    //   DRIVE, cnt = 0  -> r_next (back-to-back slots, PRESCALE = 1)
    //   DRIVE, cnt = 1  -> r_sel
    always_comb begin
        w_mask_any = |digit_mask;
        w_low      = f_lowest(digit_mask);
        case (r_state)
            S_IDLE:  w_la_base = w_low;
            S_DRIVE: w_la_base = (r_cnt == '0) ? r_next : r_sel;
            default: w_la_base = r_sel;
        endcase
        w_above   = f_above(digit_mask, w_la_base);
        w_la_wrap = ~w_above[SEL_W];
        w_la_next = w_above[SEL_W] ? w_above[SEL_W-1:0] : w_low;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_sel        <= '0;
            r_next       <= '0;
            r_next_vld   <= 1'b0;
            r_digit      <= OFF;
            r_slot_start <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_slot_start <= 1'b0;
            r_frame_done <= 1'b0;
            if (!enable) begin
                // Go dark at once. dig_sel keeps its last value.
                r_state    <= S_IDLE;
                r_cnt      <= '0;
                r_next_vld <= 1'b0;
                r_digit    <= OFF;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_digit <= OFF;
                        if (w_mask_any) begin
                            r_sel <= w_low;
                            if (BLANK_CYCLES > 0) begin
                                r_state <= S_BLANK;
                                r_cnt   <= BLK_LOAD;
                            end else begin
                                r_state      <= S_DRIVE;
                                r_cnt        <= DRV_LOAD;
                                r_digit      <= f_drive(w_low);
                                r_slot_start <= 1'b1;
                                if (PRESCALE == 1) begin
                                    r_next       <= w_la_next;
                                    r_next_vld   <= w_mask_any;
                                    r_frame_done <= w_mask_any & w_la_wrap;
                                end
                            end
                        end
                    end

                    S_BLANK: begin
                        if (r_cnt == '0) begin
                            r_state      <= S_DRIVE;
                            r_cnt        <= DRV_LOAD;
                            r_digit      <= f_drive(r_sel);
                            r_slot_start <= 1'b1;
                            if (PRESCALE == 1) begin
                                r_next       <= w_la_next;
                                r_next_vld   <= w_mask_any;
                                r_frame_done <= w_mask_any & w_la_wrap;
                            end
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end

                    S_DRIVE: begin
                        if (r_cnt == '0) begin
                            // Slot end. Use the decision latched on the previous edge.
                            if (!r_next_vld) begin
                                r_state <= S_IDLE;
                                r_digit <= OFF;
                            end else begin
                                r_sel <= r_next;
                                if (BLANK_CYCLES > 0) begin
                                    r_state <= S_BLANK;
                                    r_cnt   <= BLK_LOAD;
                                    r_digit <= OFF;
                                end else begin
                                    r_cnt        <= DRV_LOAD;
                                    r_digit      <= f_drive(r_next);
                                    r_slot_start <= 1'b1;
                                    if (PRESCALE == 1) begin
                                        r_next       <= w_la_next;
                                        r_next_vld   <= w_mask_any;
                                        r_frame_done <= w_mask_any & w_la_wrap;
                                    end
                                end
                            end
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                            // Entering the final cycle of this slot.
                            if ((PRESCALE > 1) && (r_cnt == CNT_W'(1))) begin
                                r_next       <= w_la_next;
                                r_next_vld   <= w_mask_any;
                                r_frame_done <= w_mask_any & w_la_wrap;
                            end
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_digit <= OFF;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign dig_sel    = r_sel;
    assign digit      = r_digit;
    assign slot_start = r_slot_start;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_digit_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_digit_scan_controller
//   Directed testbench. DUT A uses a 4-digit, active-low configuration with a
//   blanking gap. DUT B uses an 8-digit, active-high, one-cycle configuration
//   with no gap. Outputs are sampled on the falling edge. Inputs change just
//   after the sample.
// ---------------------------------------------------------------------------
module tb_digit_scan_controller;

    logic       clk;
    logic       rst_n;
    logic       en_a, en_b;
    logic [3:0] mask_a;
    logic [7:0] mask_b;
    logic [1:0] sel_a;
    logic [2:0] sel_b;
    logic [3:0] digit_a;
    logic [7:0] digit_b;
    logic       ss_a, fd_a, ss_b, fd_b;

    int n_chk  = 0;
    int n_fail = 0;

    digit_scan_controller #(
        .NUM_DIGITS(4), .SEL_W(2), .PRESCALE(3), .BLANK_CYCLES(1), .ACTIVE_LOW(1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .digit_mask(mask_a),
        .dig_sel(sel_a), .digit(digit_a), .slot_start(ss_a), .frame_done(fd_a)
    );

    digit_scan_controller #(
        .NUM_DIGITS(8), .SEL_W(3), .PRESCALE(1), .BLANK_CYCLES(0), .ACTIVE_LOW(0)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .digit_mask(mask_b),
        .dig_sel(sel_b), .digit(digit_b), .slot_start(ss_b), .frame_done(fd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait one cycle, then check every output of DUT A.
    task automatic cyc(input string tag, input logic [3:0] dig, input int sel,
                       input bit ss, input bit fd);
        @(negedge clk);
        chk({tag, "_dig"}, 32'(digit_a), 32'(dig));
        chk({tag, "_sel"}, 32'(sel_a), sel);
        chk({tag, "_ss"},  32'(ss_a), 32'(ss));
        chk({tag, "_fd"},  32'(fd_a), 32'(fd));
    endtask

    // Full slot on DUT A: one blank cycle, then three drive cycles.
    task automatic slot(input string tag, input int s, input bit fd);
        logic [3:0] d;
        d = ~(4'b0001 << s);
        cyc(tag, 4'hF, s, 1'b0, 1'b0);
        cyc(tag, d,    s, 1'b1, 1'b0);
        cyc(tag, d,    s, 1'b0, 1'b0);
        cyc(tag, d,    s, 1'b0, fd);
    endtask

    initial begin
        rst_n  = 1'b0;
        en_a   = 1'b0;
        en_b   = 1'b0;
        mask_a = 4'h0;
        mask_b = 8'h00;

        // 1: reset held while inputs toggle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_dig", 32'(digit_a), 32'h0000_000F);
            chk("rst_sel", 32'(sel_a), 32'd0);
            chk("rst_ss",  32'(ss_a), 32'd0);
            chk("rst_fd",  32'(fd_a), 32'd0);
            chk("rst_dig_b", 32'(digit_b), 32'd0);
            en_a   = i[0];
            mask_a = 4'(i * 5 + 3);
        end
        en_a   = 1'b0;
        mask_a = 4'hF;
        rst_n  = 1'b1;
        cyc("idle", 4'hF, 0, 1'b0, 1'b0);
        cyc("idle", 4'hF, 0, 1'b0, 1'b0);
        cyc("idle", 4'hF, 0, 1'b0, 1'b0);

        // 2: full scan, two frames
        en_a = 1'b1;
        for (int f = 0; f < 2; f++)
            for (int s = 0; s < 4; s++)
                slot("t2", s, s == 3);

        // 3: digits 0 and 2 only, then mask shrinks during the slot for digit 0
        en_a = 1'b0;
        cyc("t3_off", 4'hF, 3, 1'b0, 1'b0);
        mask_a = 4'b0101;
        en_a   = 1'b1;
        slot("t3", 0, 1'b0);
        slot("t3", 2, 1'b1);
        cyc("t3m", 4'hF, 0, 1'b0, 1'b0);
        cyc("t3m", 4'hE, 0, 1'b1, 1'b0);
        mask_a = 4'b0100;
        cyc("t3m", 4'hE, 0, 1'b0, 1'b0);
        cyc("t3m", 4'hE, 0, 1'b0, 1'b0);
        slot("t3s", 2, 1'b1);
        slot("t3s", 2, 1'b1);

        // 4: mask cleared during DRIVE -> slot completes, then IDLE
        cyc("t4", 4'hF, 2, 1'b0, 1'b0);
        cyc("t4", 4'hB, 2, 1'b1, 1'b0);
        mask_a = 4'b0000;
        cyc("t4", 4'hB, 2, 1'b0, 1'b0);
        cyc("t4", 4'hB, 2, 1'b0, 1'b0);
        cyc("t4_idle", 4'hF, 2, 1'b0, 1'b0);
        cyc("t4_idle", 4'hF, 2, 1'b0, 1'b0);
        cyc("t4_idle", 4'hF, 2, 1'b0, 1'b0);
        mask_a = 4'b0010;
        slot("t4_res", 1, 1'b1);

        // 5: enable drop on the second DRIVE cycle of digit 2
        en_a = 1'b0;
        cyc("t5_off", 4'hF, 1, 1'b0, 1'b0);
        mask_a = 4'hF;
        en_a   = 1'b1;
        slot("t5", 0, 1'b0);
        slot("t5", 1, 1'b0);
        cyc("t5", 4'hF, 2, 1'b0, 1'b0);
        cyc("t5", 4'hB, 2, 1'b1, 1'b0);
        cyc("t5", 4'hB, 2, 1'b0, 1'b0);
        en_a = 1'b0;
        cyc("t5_drop", 4'hF, 2, 1'b0, 1'b0);
        cyc("t5_drop", 4'hF, 2, 1'b0, 1'b0);

        //    asynchronous reset pulse in the middle of DRIVE for digit 1
        en_a = 1'b1;
        slot("t5r", 0, 1'b0);
        cyc("t5r", 4'hF, 1, 1'b0, 1'b0);
        cyc("t5r", 4'hD, 1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_arst_dig", 32'(digit_a), 32'h0000_000F);
        chk("t5_arst_sel", 32'(sel_a), 32'd0);
        chk("t5_arst_ss",  32'(ss_a), 32'd0);
        en_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc("t5_post", 4'hF, 0, 1'b0, 1'b0);

        // 6: 8 digits, one cycle each, no gap, active high
        mask_b = 8'hFF;
        en_b   = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("t6_dig", 32'(digit_b), 32'(8'b1 << (k % 8)));
            chk("t6_sel", 32'(sel_b), 32'(k % 8));
            chk("t6_ss",  32'(ss_b), 32'd1);
            chk("t6_fd",  32'(fd_b), 32'((k % 8) == 7));
            chk("t6_one", $countones(digit_b), 32'd1);
        end
        en_b = 1'b0;
        @(negedge clk);
        chk("t6_off", 32'(digit_b), 32'd0);
        chk("t6_off_ss", 32'(ss_b), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
